m_lsu_seq: RTL

- Multi-cycle load/store unit for the MEM stage. It is the parametrised successor of the combinational load-data extractor.
- Handles byte, halfword and word loads and stores, including sign and zero extension and store byte-enable generation.
- Misaligned accesses that cross a word boundary are either split into two aligned memory transactions or flagged as an exception.
- Generalises the "more ones than zeros" check to the actual loaded width.

---
 rtl/m_lsu_seq.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/m_lsu_seq.sv
// Multi-cycle load/store unit for the MEM stage.
// Handles LW/LH/LHU/LB/LBU/SW/SH/SB with sign/zero extension and store byte
// enables. Accesses crossing a word boundary are split into two aligned
// memory transactions, or raise an alignment exception when MISALIGN_EN=0.
// Also reports whether the loaded field holds more ones than zeros.
module m_lsu_seq #(
  parameter bit MISALIGN_EN = 1'b1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_ones_gt,
  output logic              resp_exc,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;

  // Access size in bytes: 4, 2 or 1.
  function automatic logic [2:0] size_of(input logic [2:0] op);
    case (op)
      3'b000, 3'b101:         return 3'd4;
      3'b001, 3'b010, 3'b110: return 3'd2;
      default:                return 3'd1;
    endcase
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return op[2] & (op[1] | op[0]);
  endfunction

  function automatic logic [5:0] popcnt(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
    return n;
  endfunction

  state_t            state, state_nx;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata0_q, rdata1_q;
  logic              exc_q;

  // In IDLE the request comes straight from the ports (it is being latched
  // on this edge); in every other state it comes from the latched copy.
  logic [2:0]        cur_op;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  assign cur_op    = (state == IDLE) ? req_op    : op_q;
  assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;

  logic [1:0] cur_off;
  logic [2:0] cur_size;
  logic       cur_cross, cur_mis;
  assign cur_off   = cur_addr[1:0];
  assign cur_size  = size_of(cur_op);
  assign cur_cross = ({1'b0, cur_off} + cur_size) > 3'd4;
  assign cur_mis   = ((cur_size == 3'd4) && (cur_off != 2'd0)) ||
                     ((cur_size == 3'd2) && cur_off[0]);

  logic              req_ready_d, mem_req_d, mem_we_d, resp_valid_d;
  logic              resp_ones_d, resp_exc_d;
  logic [3:0]        mem_be_d;
  logic [ADDR_W-1:0] mem_addr_d, base;
  logic [31:0]       mem_wdata_d, resp_rdata_d, field, ld_data;
  logic [3:0]        mask4;
  logic [7:0]        be64;
  logic [63:0]       w64;
  logic              ld_ones, in_acc1;

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_be       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_ones_gt <= 1'b0;
      resp_exc     <= 1'b0;
    end else begin
      state        <= state_nx;
      req_ready    <= req_ready_d;
      mem_req      <= mem_req_d;
      mem_we       <= mem_we_d;
      mem_be       <= mem_be_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      resp_valid   <= resp_valid_d;
      resp_rdata   <= resp_rdata_d;
      resp_ones_gt <= resp_ones_d;
      resp_exc     <= resp_exc_d;
    end
  end

  // Latch the accepted request and capture read data on each ack.
  always_ff @(posedge clk) begin
    // NOTE: these datapath registers are not reset; they are always written
    // before the FSM reads them, so a reset would only cost routing.
    if (state == IDLE && req_valid) begin
      op_q     <= req_op;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      exc_q    <= !MISALIGN_EN && cur_mis;
      rdata1_q <= '0;
    end
    if (state == ACC0 && mem_ack) rdata0_q <= mem_rdata;
    if (state == ACC1 && mem_ack) rdata1_q <= mem_rdata;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nx unassigned,
    // which would infer a latch.
    state_nx = state;
    unique case (state)
      IDLE:    if (req_valid) state_nx = (!MISALIGN_EN && cur_mis) ? RESP : ACC0;
      ACC0:    if (mem_ack)   state_nx = cur_cross ? ACC1 : RESP;
      ACC1:    if (mem_ack)   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    unique case (cur_size)
      3'd1:    mask4 = 4'b0001;
      3'd2:    mask4 = 4'b0011;
      default: mask4 = 4'b1111;
    endcase
    be64    = {4'b0000, mask4} << cur_off;
    w64     = {32'b0, cur_wdata} << {cur_off, 3'b000};
    base    = {cur_addr[ADDR_W-1:2], 2'b00};
    in_acc1 = (state_nx == ACC1);

    req_ready_d = (state_nx == IDLE);
    mem_req_d   = (state_nx == ACC0) || (state_nx == ACC1);
    mem_we_d    = 1'b0;
    mem_be_d    = '0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (mem_req_d) begin
      mem_addr_d = in_acc1 ? base + ADDR_W'(4) : base;
      mem_we_d   = is_store(cur_op);
      mem_be_d   = in_acc1 ? be64[7:4] : be64[3:0];
      if (is_store(cur_op)) mem_wdata_d = in_acc1 ? w64[63:32] : w64[31:0];
    end

    // Load field: the two captured words shifted down by the byte offset.
    field   = 32'({rdata1_q, rdata0_q} >> {cur_off, 3'b000});
    ld_data = '0;
    ld_ones = 1'b0;
    case (cur_op)
      OP_LW:  begin ld_data = field;                              ld_ones = popcnt(field) > 6'd16; end
      OP_LH:  begin ld_data = {{16{field[15]}}, field[15:0]};     ld_ones = popcnt({16'b0, field[15:0]}) > 6'd8; end
      OP_LHU: begin ld_data = {16'b0, field[15:0]};               ld_ones = popcnt({16'b0, field[15:0]}) > 6'd8; end
      OP_LB:  begin ld_data = {{24{field[7]}}, field[7:0]};       ld_ones = popcnt({24'b0, field[7:0]}) > 6'd4; end
      OP_LBU: begin ld_data = {24'b0, field[7:0]};                ld_ones = popcnt({24'b0, field[7:0]}) > 6'd4; end
      default: ;
    endcase

    resp_valid_d = (state == RESP);
    resp_rdata_d = resp_rdata;
    resp_ones_d  = resp_ones_gt;
    resp_exc_d   = resp_exc;
    if (state == RESP) begin
      resp_exc_d   = exc_q;
      resp_rdata_d = exc_q ? 32'h0 : ld_data;
      resp_ones_d  = exc_q ? 1'b0  : ld_ones;
    end
  end

endmodule
